// File: rtl/test3_pkg.sv
// test3_pkg: shared constants, bank state enum and occupancy-width helper for test3_demux
package test3_pkg;
  localparam int DEF_WIDTH = 17;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} bank_state_e;
  // Occupancy needs one bit more than a pointer so that FULL (== DEPTH) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/test3_bank.sv
// test3_bank: one enable-loaded FIFO bank with first-word fall-through head
// Ports: clk, rst (async, active-low); din/push write side (push already qualified by room);
//        room = not full; dout/valid/ready head handshake; count = occupancy.
// With TEST3_DEMUX_ACT_CNT_EN defined, act counts pushes and saturates at all-ones.
module test3_bank import test3_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
`ifdef TEST3_DEMUX_ACT_CNT_EN
  , parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      push,
  output logic                      room,
  output logic [WIDTH-1:0]          dout,
  output logic                      valid,
  input  logic                      ready,
  output logic [cnt_w(DEPTH)-1:0]   count
`ifdef TEST3_DEMUX_ACT_CNT_EN
  , output logic [CNT_W-1:0]        act
`endif
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = CW - 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  bank_state_e state;
  logic we, pop;
  always_comb begin
    state = count == '0 ? EMPTY : count == CW'(DEPTH) ? FULL : PARTIAL;
  end
  assign valid = state != EMPTY;
  assign room  = state != FULL;
  // A full bank never accepts, even when it pops in the same cycle.
  assign we    = push & room;
  assign pop   = valid & ready;
  assign dout  = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (we) mem[wr_ptr] <= din;
      if (we) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(we) - CW'(pop);
    end
  end
`ifdef TEST3_DEMUX_ACT_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) act <= '0;
    else if (we && act != '1) act <= act + 1'b1;
  end
`endif
endmodule

// File: rtl/test3_demux.sv
// test3_demux: routes a valid/ready word stream into bank A (s=1) or bank B (s=0)
// Ports: clk, rst (async, active-low); x/s/x_valid/x_ready input stream;
//        a/a_valid/a_ready and b/b_valid/b_ready bank heads; a_count/b_count occupancy.
// Optional macro TEST3_DEMUX_ACT_CNT_EN adds saturating push counters act_a/act_b.
module test3_demux import test3_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
`ifdef TEST3_DEMUX_ACT_CNT_EN
  , parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        x,
  input  logic                    s,
  input  logic                    x_valid,
  output logic                    x_ready,
  output logic [WIDTH-1:0]        a,
  output logic                    a_valid,
  input  logic                    a_ready,
  output logic [WIDTH-1:0]        b,
  output logic                    b_valid,
  input  logic                    b_ready,
  output logic [cnt_w(DEPTH)-1:0] a_count,
  output logic [cnt_w(DEPTH)-1:0] b_count
`ifdef TEST3_DEMUX_ACT_CNT_EN
  , output logic [CNT_W-1:0]      act_a
  , output logic [CNT_W-1:0]      act_b
`endif
);
  logic a_room, b_room, a_push, b_push;
  // Ready depends only on s and bank occupancy, never on downstream ready.
  assign x_ready = s ? a_room : b_room;
  assign a_push  = x_valid & x_ready & s;
  assign b_push  = x_valid & x_ready & ~s;
  test3_bank #(
    .WIDTH(WIDTH), .DEPTH(DEPTH)
`ifdef TEST3_DEMUX_ACT_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) u_a (
    .clk(clk), .rst(rst), .din(x), .push(a_push), .room(a_room),
    .dout(a), .valid(a_valid), .ready(a_ready), .count(a_count)
`ifdef TEST3_DEMUX_ACT_CNT_EN
    , .act(act_a)
`endif
  );
  test3_bank #(
    .WIDTH(WIDTH), .DEPTH(DEPTH)
`ifdef TEST3_DEMUX_ACT_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) u_b (
    .clk(clk), .rst(rst), .din(x), .push(b_push), .room(b_room),
    .dout(b), .valid(b_valid), .ready(b_ready), .count(b_count)
`ifdef TEST3_DEMUX_ACT_CNT_EN
    , .act(act_b)
`endif
  );
endmodule

// File: tb/tb_test3_demux.sv
// tb_test3_demux: directed and randomized checks of test3_demux against a queue-based model
module tb_test3_demux;
  import test3_pkg::*;
  localparam int W = DEF_WIDTH;
  localparam int D = DEF_DEPTH;
  localparam int CW = $clog2(D) + 1;
  logic clk = 0, rst = 0, s = 0, x_valid = 0, a_ready = 0, b_ready = 0;
  logic [W-1:0] x = '0, a, b;
  logic x_ready, a_valid, b_valid;
  logic [CW-1:0] a_count, b_count;
  int n_cmp = 0, n_err = 0;
  logic [W-1:0] qa[$], qb[$];
`ifdef TEST3_DEMUX_ACT_CNT_EN
  logic [DEF_CNT_W-1:0] act_a, act_b;
  logic [2:0] sat_a, sat_b;
  logic [W-1:0] s_a, s_b;
  logic s_xr, s_av, s_bv;
  logic [CW-1:0] s_ac, s_bc;
`endif

  always #5 clk = ~clk;

  test3_demux dut (
    .clk(clk), .rst(rst), .x(x), .s(s), .x_valid(x_valid), .x_ready(x_ready),
    .a(a), .a_valid(a_valid), .a_ready(a_ready),
    .b(b), .b_valid(b_valid), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
`ifdef TEST3_DEMUX_ACT_CNT_EN
    , .act_a(act_a), .act_b(act_b)
`endif
  );

`ifdef TEST3_DEMUX_ACT_CNT_EN
  test3_demux #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .x(x), .s(s), .x_valid(x_valid), .x_ready(s_xr),
    .a(s_a), .a_valid(s_av), .a_ready(a_ready),
    .b(s_b), .b_valid(s_bv), .b_ready(b_ready),
    .a_count(s_ac), .b_count(s_bc), .act_a(sat_a), .act_b(sat_b)
  );
`endif

  task automatic set_in(input logic [W-1:0] vx, input logic vs, input logic vv, input logic ar, input logic br);
    x = vx; s = vs; x_valid = vv; a_ready = ar; b_ready = br;
    #1;
  endtask

  // Model: a bank accepts when it holds fewer than D words (judged before this edge's pop).
  task automatic tick();
    bit acc, pa, pb;
    acc = x_valid && (s ? qa.size() < D : qb.size() < D);
    pa = a_ready && qa.size() > 0;
    pb = b_ready && qb.size() > 0;
    @(posedge clk);
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (acc) begin
      if (s) qa.push_back(x);
      else qb.push_back(x);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_in(W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_err++; $display("FAIL rst_hold_valid: got a=%b b=%b want 0 0", a_valid, b_valid); end
    @(negedge clk);
    rst = 1;
    set_in('0, 1'b1, 1'b0, 1'b0, 1'b0);
    qa.delete(); qb.delete();
    n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got a=%b b=%b want 0 0", a_valid, b_valid); end
    n_cmp++; if (a_count !== '0 || b_count !== '0) begin n_err++; $display("FAIL rst_count: got a=%0d b=%0d want 0 0", a_count, b_count); end
    n_cmp++; if (a !== '0 || b !== '0) begin n_err++; $display("FAIL rst_data: got a=%0h b=%0h want 0 0", a, b); end
    n_cmp++; if (x_ready !== 1'b1) begin n_err++; $display("FAIL rst_x_ready: got %b want 1", x_ready); end
  endtask

  task automatic test_routing();
    set_in(W'(2), 1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL route_latency: got a_valid=%b want 0 before accept edge", a_valid); end
    tick();
    n_cmp++; if (a_valid !== 1'b1 || a !== W'(2) || a_count !== CW'(1)) begin n_err++; $display("FAIL route_a: got v=%b d=%0d c=%0d want 1 2 1", a_valid, a, a_count); end
    n_cmp++; if (b_valid !== 1'b0 || b_count !== '0) begin n_err++; $display("FAIL route_no_cross_b: got v=%b c=%0d want 0 0", b_valid, b_count); end
    set_in(W'(1), 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    n_cmp++; if (b_valid !== 1'b1 || b !== W'(1) || b_count !== CW'(1)) begin n_err++; $display("FAIL route_b: got v=%b d=%0d c=%0d want 1 1 1", b_valid, b, b_count); end
    n_cmp++; if (a_valid !== 1'b0 || a_count !== '0) begin n_err++; $display("FAIL route_no_cross_a: got v=%b c=%0d want 0 0", a_valid, a_count); end
    set_in('0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    n_cmp++; if (b_valid !== 1'b0) begin n_err++; $display("FAIL route_drain: got b_valid=%b want 0", b_valid); end
  endtask

  task automatic test_full();
    set_in(W'(3), 1'b1, 1'b1, 1'b0, 1'b1); tick();
    set_in(W'(4), 1'b1, 1'b1, 1'b0, 1'b1); tick();
    n_cmp++; if (a_count !== CW'(2) || a !== W'(3)) begin n_err++; $display("FAIL full_count: got c=%0d d=%0d want 2 3", a_count, a); end
    set_in(W'(5), 1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (x_ready !== 1'b0) begin n_err++; $display("FAIL full_x_ready: got %b want 0", x_ready); end
    tick();
    n_cmp++; if (a_count !== CW'(2) || a !== W'(3) || a_valid !== 1'b1) begin n_err++; $display("FAIL full_hold: got c=%0d d=%0d v=%b want 2 3 1", a_count, a, a_valid); end
    set_in(W'(5), 1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (x_ready !== 1'b0) begin n_err++; $display("FAIL full_no_passthru: got x_ready=%b want 0", x_ready); end
    tick();
    n_cmp++; if (a_count !== CW'(1) || a !== W'(4)) begin n_err++; $display("FAIL full_pop3: got c=%0d d=%0d want 1 4", a_count, a); end
    set_in(W'(5), 1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (x_ready !== 1'b1) begin n_err++; $display("FAIL full_reopen: got x_ready=%b want 1", x_ready); end
    tick();
    n_cmp++; if (a_count !== CW'(2) || a !== W'(4)) begin n_err++; $display("FAIL full_push5: got c=%0d d=%0d want 2 4", a_count, a); end
    set_in('0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    n_cmp++; if (a_count !== CW'(1) || a !== W'(5)) begin n_err++; $display("FAIL full_order5: got c=%0d d=%0d want 1 5", a_count, a); end
    tick();
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL full_drain: got a_valid=%b want 0", a_valid); end
  endtask

  task automatic test_simul();
    set_in(W'(7), 1'b0, 1'b1, 1'b1, 1'b0); tick();
    set_in(W'(8), 1'b0, 1'b1, 1'b1, 1'b1); tick();
    n_cmp++; if (b_count !== CW'(1) || b !== W'(8)) begin n_err++; $display("FAIL simul_b: got c=%0d d=%0d want 1 8", b_count, b); end
    set_in('0, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    n_cmp++; if (b_valid !== 1'b0) begin n_err++; $display("FAIL simul_b_drain: got b_valid=%b want 0", b_valid); end
    set_in(W'(10), 1'b1, 1'b1, 1'b0, 1'b1); tick();
    set_in(W'(11), 1'b1, 1'b1, 1'b0, 1'b1); tick();
    set_in(W'(12), 1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (x_ready !== 1'b0) begin n_err++; $display("FAIL simul_a_full_ready: got %b want 0", x_ready); end
    tick();
    n_cmp++; if (a_count !== CW'(1) || a !== W'(11)) begin n_err++; $display("FAIL simul_a_pop_only: got c=%0d d=%0d want 1 11", a_count, a); end
    set_in('0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
  endtask

  task automatic test_random();
    bit exp_rdy;
    for (int i = 0; i < 400; i++) begin
      set_in(W'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      exp_rdy = s ? qa.size() < D : qb.size() < D;
      n_cmp++; if (x_ready !== exp_rdy) begin n_err++; $display("FAIL rand_x_ready[%0d]: got %b want %b", i, x_ready, exp_rdy); end
      tick();
      n_cmp++; if (a_valid !== (qa.size() > 0) || a_count !== CW'(qa.size())) begin n_err++; $display("FAIL rand_a_state[%0d]: got v=%b c=%0d want c=%0d", i, a_valid, a_count, qa.size()); end
      n_cmp++; if (b_valid !== (qb.size() > 0) || b_count !== CW'(qb.size())) begin n_err++; $display("FAIL rand_b_state[%0d]: got v=%b c=%0d want c=%0d", i, b_valid, b_count, qb.size()); end
      if (qa.size() > 0) begin
        n_cmp++; if (a !== qa[0]) begin n_err++; $display("FAIL rand_a_data[%0d]: got %0h want %0h", i, a, qa[0]); end
      end
      if (qb.size() > 0) begin
        n_cmp++; if (b !== qb[0]) begin n_err++; $display("FAIL rand_b_data[%0d]: got %0h want %0h", i, b, qb[0]); end
      end
    end
    set_in('0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) tick();
  endtask

  task automatic test_mid_reset();
    set_in(W'(1), 1'b1, 1'b1, 1'b0, 1'b0); tick();
    set_in(W'(2), 1'b1, 1'b1, 1'b0, 1'b0); tick();
    set_in(W'(3), 1'b0, 1'b1, 1'b0, 1'b0); tick();
    set_in(W'(4), 1'b0, 1'b1, 1'b0, 1'b0); tick();
    n_cmp++; if (a_count !== CW'(2) || b_count !== CW'(2)) begin n_err++; $display("FAIL mid_fill: got a=%0d b=%0d want 2 2", a_count, b_count); end
    set_in('0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 0;
    #1;
    n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got a=%b b=%b want 0 0", a_valid, b_valid); end
    n_cmp++; if (a_count !== '0 || b_count !== '0) begin n_err++; $display("FAIL mid_count: got a=%0d b=%0d want 0 0", a_count, b_count); end
    qa.delete(); qb.delete();
    @(negedge clk);
    rst = 1;
    set_in(W'(3), 1'b1, 1'b1, 1'b0, 1'b0); tick();
    n_cmp++; if (a_valid !== 1'b1 || a !== W'(3) || a_count !== CW'(1)) begin n_err++; $display("FAIL mid_after: got v=%b d=%0d c=%0d want 1 3 1", a_valid, a, a_count); end
  endtask

`ifdef TEST3_DEMUX_ACT_CNT_EN
  task automatic test_act_cnt();
    @(negedge clk);
    rst = 0;
    #1 rst = 1;
    qa.delete(); qb.delete();
    for (int i = 0; i < 5; i++) begin set_in(W'(i), 1'b1, 1'b1, 1'b1, 1'b1); tick(); end
    for (int i = 0; i < 2; i++) begin set_in(W'(i), 1'b0, 1'b1, 1'b1, 1'b1); tick(); end
    n_cmp++; if (act_a !== 16'd5 || act_b !== 16'd2) begin n_err++; $display("FAIL act_count: got a=%0d b=%0d want 5 2", act_a, act_b); end
    for (int i = 0; i < 4; i++) begin set_in(W'(i), 1'b1, 1'b1, 1'b1, 1'b1); tick(); end
    n_cmp++; if (act_a !== 16'd9) begin n_err++; $display("FAIL act_count9: got %0d want 9", act_a); end
    n_cmp++; if (sat_a !== 3'd7 || sat_b !== 3'd2) begin n_err++; $display("FAIL act_saturate: got a=%0d b=%0d want 7 2", sat_a, sat_b); end
    set_in('0, 1'b0, 1'b0, 1'b1, 1'b1); tick();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_routing();
    test_full();
    test_simul();
    test_random();
    test_mid_reset();
`ifdef TEST3_DEMUX_ACT_CNT_EN
    test_act_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
